// File: rtl/clk_switch_pkg.sv
// clk_switch_pkg: state encoding and fault codes shared by the clock switch sequencer
package clk_switch_pkg;
    typedef enum logic [1:0] {ST_STABLE, ST_QUALIFY, ST_SETTLE, ST_PROG} state_t;
    localparam logic [1:0] FAULT_NONE = 2'd0;
    localparam logic [1:0] FAULT_LOCK = 2'd1;
    localparam logic [1:0] FAULT_LOW  = 2'd2;
    localparam logic [1:0] FAULT_HIGH = 2'd3;
endpackage

// File: rtl/clk_activity_meter.sv
// clk_activity_meter: synchronizes prog_toggle and counts its level changes per fixed stable-clock window
module clk_activity_meter
    import clk_switch_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1024,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             prog_toggle,
    input  logic             run,
    output logic             window_done,
    output logic [CNT_W-1:0] count
);
    logic [2:0]       tog_sync_q, tog_sync_d;
    logic [CNT_W-1:0] win_q, win_d, tog_q, tog_d;
    logic             edge_evt;
    always_comb begin
        tog_sync_d  = {tog_sync_q[1:0], prog_toggle};
        edge_evt    = tog_sync_q[1] ^ tog_sync_q[2];
        window_done = run && win_q == CNT_W'(WINDOW_CYCLES - 1);
        // count includes this cycle's event so the terminal cycle reports the full window
        count       = (edge_evt && !(&tog_q)) ? tog_q + 1'b1 : tog_q;
        win_d       = (!run || window_done) ? '0 : win_q + 1'b1;
        tog_d       = (!run || window_done) ? '0 : count;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            tog_sync_q <= '0;
            win_q      <= '0;
            tog_q      <= '0;
        end else begin
            tog_sync_q <= tog_sync_d;
            win_q      <= win_d;
            tog_q      <= tog_d;
        end
    end
endmodule

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: glitch-free mux select sequencer; CLK_SWITCH_ACTIVITY_MON_EN keeps activity windows running in PROG
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1024,
    parameter int MIN_TOGGLES   = 400,
    parameter int MAX_TOGGLES   = 600,
    parameter int SETTLE_CYCLES = 64,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             prog_locked,
    input  logic             prog_toggle,
    input  logic             switch_req,
    input  logic             revert_req,
    input  logic             fault_clr,
    output logic             clk_select,
    output logic             on_prog,
    output logic             busy,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] last_count
);
    state_t           state_q, state_d;
    logic [1:0]       lock_sync_q, lock_sync_d;
    logic [CNT_W-1:0] settle_q, settle_d, last_count_q, last_count_d, count;
    logic [1:0]       fault_code_q, fault_code_d, new_fault, win_code;
    logic             fault_q, fault_d, clk_select_q, clk_select_d;
    logic             on_prog_q, on_prog_d, busy_q, busy_d;
    logic             run, window_done, lock, in_range, settle_done;
    clk_activity_meter #(
        .WINDOW_CYCLES(WINDOW_CYCLES),
        .CNT_W        (CNT_W)
    ) u_meter (
        .clk        (clk),
        .reset      (reset),
        .prog_toggle(prog_toggle),
        .run        (run),
        .window_done(window_done),
        .count      (count)
    );
    always_comb begin
        lock_sync_d  = {lock_sync_q[0], prog_locked};
        lock         = lock_sync_q[1];
`ifdef CLK_SWITCH_ACTIVITY_MON_EN
        run          = state_q == ST_QUALIFY || state_q == ST_PROG;
`else
        run          = state_q == ST_QUALIFY;
`endif
        in_range     = count >= CNT_W'(MIN_TOGGLES) && count <= CNT_W'(MAX_TOGGLES);
        win_code     = count < CNT_W'(MIN_TOGGLES) ? FAULT_LOW : FAULT_HIGH;
        settle_done  = settle_q == CNT_W'(SETTLE_CYCLES - 1);
        settle_d     = state_q == ST_SETTLE && !settle_done ? settle_q + 1'b1 : '0;
        last_count_d = window_done ? count : last_count_q;
        state_d      = state_q;
        new_fault    = FAULT_NONE;
        case (state_q)
            ST_STABLE:
                if (switch_req && !revert_req && !fault_q && lock) state_d = ST_QUALIFY;
            ST_QUALIFY:
                if (!lock) new_fault = FAULT_LOCK;
                else if (revert_req) state_d = ST_STABLE;
                else if (window_done) begin
                    state_d   = in_range ? ST_SETTLE : ST_STABLE;
                    new_fault = in_range ? FAULT_NONE : win_code;
                end
            ST_SETTLE:
                if (!lock) new_fault = FAULT_LOCK;
                else if (revert_req) state_d = ST_STABLE;
                else if (settle_done) state_d = ST_PROG;
            ST_PROG:
                if (!lock) new_fault = FAULT_LOCK;
                else if (revert_req) state_d = ST_STABLE;
`ifdef CLK_SWITCH_ACTIVITY_MON_EN
                else if (window_done && !in_range) new_fault = win_code;
`endif
            default: state_d = ST_STABLE;
        endcase
        // any fault forces fallback and beats a same-cycle clear
        state_d      = new_fault != FAULT_NONE ? ST_STABLE : state_d;
        fault_d      = new_fault != FAULT_NONE || (fault_q && !fault_clr);
        fault_code_d = new_fault != FAULT_NONE ? new_fault : fault_clr ? FAULT_NONE : fault_code_q;
        clk_select_d = state_d != ST_PROG;
        on_prog_d    = state_d == ST_PROG;
        busy_d       = state_d == ST_QUALIFY || state_d == ST_SETTLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_STABLE;
            lock_sync_q  <= '0;
            settle_q     <= '0;
            last_count_q <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
            clk_select_q <= 1'b1;
            on_prog_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_sync_q  <= lock_sync_d;
            settle_q     <= settle_d;
            last_count_q <= last_count_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            clk_select_q <= clk_select_d;
            on_prog_q    <= on_prog_d;
            busy_q       <= busy_d;
        end
    end
    assign clk_select = clk_select_q;
    assign on_prog    = on_prog_q;
    assign busy       = busy_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign last_count = last_count_q;
endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb_clk_switch_ctrl: directed checks of qualification, fallback, abort and fault handling
module tb_clk_switch_ctrl;
    logic        clk = 0, reset = 1, prog_locked = 0, prog_toggle = 0;
    logic        switch_req = 0, revert_req = 0, fault_clr = 0;
    logic        clk_select, on_prog, busy, fault;
    logic [1:0]  fault_code;
    logic [15:0] last_count;
    int          total = 0, bad = 0, rate = 0, phase = 0;
    int          n_busy, first, saw_prog;
    always #5 clk = ~clk;
    clk_switch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .prog_locked(prog_locked),
        .prog_toggle(prog_toggle),
        .switch_req (switch_req),
        .revert_req (revert_req),
        .fault_clr  (fault_clr),
        .clk_select (clk_select),
        .on_prog    (on_prog),
        .busy       (busy),
        .fault      (fault),
        .fault_code (fault_code),
        .last_count (last_count)
    );
    // periodic pattern: exactly `rate` toggles in any 1024 consecutive cycles
    initial begin : toggle_gen
        int p;
        forever begin
            @(negedge clk);
            p = phase % 1024;
            if (((p + 1) * rate) / 1024 != (p * rate) / 1024) prog_toggle = ~prog_toggle;
            phase++;
        end
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
        tick(3);
        check("rst_clk_select", clk_select, 1);
        check("rst_busy", busy, 0);
        reset = 0;
        tick(2);
        check("idle_clk_select", clk_select, 1);
        check("idle_on_prog", on_prog, 0);
        check("idle_fault", fault, 0);
        check("idle_code", fault_code, 0);
        check("idle_last_count", last_count, 0);
        // qualify at 500 toggles and switch
        prog_locked = 1;
        rate = 500;
        tick(1100);
        switch_req = 1;
        n_busy = 0;
        first = 0;
        for (int k = 1; k <= 1200; k++) begin
            tick(1);
            if (busy) n_busy++;
            if (!clk_select && first == 0) first = k;
        end
        check("sw_busy_cycles", n_busy, 1088);
        check("sw_select_cycle", first, 1089);
        check("sw_on_prog", on_prog, 1);
        check("sw_last_count", last_count, 500);
        check("sw_fault", fault, 0);
        // lock loss in PROG
        prog_locked = 0;
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (clk_select && first == 0) first = k;
        end
        check("lock_fall_cycle", first, 3);
        check("lock_fault", fault, 1);
        check("lock_code", fault_code, 1);
        check("lock_on_prog", on_prog, 0);
        switch_req = 0;
        fault_clr = 1;
        tick(1);
        fault_clr = 0;
        check("clr_fault", fault, 0);
        check("clr_code", fault_code, 0);
        // low activity
        prog_locked = 1;
        rate = 300;
        tick(1100);
        switch_req = 1;
        saw_prog = 0;
        for (int k = 1; k <= 1100; k++) begin
            tick(1);
            if (!clk_select) saw_prog = 1;
        end
        check("low_never_prog", saw_prog, 0);
        check("low_fault", fault, 1);
        check("low_code", fault_code, 2);
        check("low_last_count", last_count, 300);
        check("low_busy", busy, 0);
        n_busy = 0;
        for (int k = 1; k <= 50; k++) begin
            tick(1);
            if (busy) n_busy++;
        end
        check("fault_blocks_switch", n_busy, 0);
        fault_clr = 1;
        tick(1);
        fault_clr = 0;
        check("clr2_fault", fault, 0);
        check("clr2_code", fault_code, 0);
        check("clr2_busy", busy, 0);
        tick(1);
        check("requalify_busy", busy, 1);
        switch_req = 0;
        revert_req = 1;
        tick(1);
        check("qual_abort_busy", busy, 0);
        check("qual_abort_fault", fault, 0);
        // switch and revert together, then abort during settle
        rate = 500;
        switch_req = 1;
        n_busy = 0;
        for (int k = 1; k <= 1100; k++) begin
            tick(1);
            if (busy) n_busy++;
        end
        check("both_req_busy", n_busy, 0);
        revert_req = 0;
        saw_prog = 0;
        for (int k = 1; k <= 1030; k++) begin
            tick(1);
            if (!clk_select) saw_prog = 1;
        end
        check("settle_busy", busy, 1);
        check("settle_last_count", last_count, 500);
        revert_req = 1;
        tick(1);
        check("settle_abort_busy", busy, 0);
        check("settle_abort_select", clk_select, 1);
        check("settle_abort_fault", fault, 0);
        check("settle_abort_on_prog", on_prog, 0);
        check("settle_never_prog", saw_prog, 0);
        // rate rises to 700 while in PROG
        revert_req = 0;
        tick(1100);
        check("prog2_on_prog", on_prog, 1);
        rate = 700;
        tick(3200);
`ifdef CLK_SWITCH_ACTIVITY_MON_EN
        check("high_on_prog", on_prog, 0);
        check("high_select", clk_select, 1);
        check("high_fault", fault, 1);
        check("high_code", fault_code, 3);
        check("high_last_gt_max", last_count > 16'd600, 1);
`else
        check("high_on_prog", on_prog, 1);
        check("high_select", clk_select, 0);
        check("high_fault", fault, 0);
        check("high_last_held", last_count, 500);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clk_switch_ctrl.md
# clk_switch_ctrl

Sequencer that owns the select input of the glitch-free clock mux choosing between the stable reference clock and the programmable clock. Runs entirely in the stable clock domain. Qualifies the programmable clock (lock held plus measured activity within bounds), waits a settle period, then switches the mux to it. Falls back to the stable clock on request or on any qualification loss, and reports a sticky fault.

## Interface
Parameters:
- WINDOW_CYCLES, 1024: stable-clock cycles per activity measurement window
- MIN_TOGGLES, 400: minimum synchronized toggle events per window to pass
- MAX_TOGGLES, 600: maximum synchronized toggle events per window to pass
- SETTLE_CYCLES, 64: stable-clock cycles between a passing window and the switch
- CNT_W, 16: width of window, settle and toggle counters

Ports:
- clk  in  1  stable clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- prog_locked  in  1  programmable clock source lock, asynchronous; internal 2-flop synchronizer
- prog_toggle  in  1  divided programmable clock toggle, asynchronous; 2-flop synchronizer plus edge-detect flop; each level change is one event
- switch_req  in  1  level; request the programmable clock
- revert_req  in  1  level; request the stable clock
- fault_clr  in  1  single-cycle pulse; clears fault and fault_code
- clk_select  out  1  mux select; 1 = stable clock, 0 = programmable clock; registered
- on_prog  out  1  high while in PROG
- busy  out  1  high in QUALIFY or SETTLE
- fault  out  1  sticky fault flag
- fault_code  out  2  0 none, 1 lock lost, 2 activity low, 3 activity high
- last_count  out  CNT_W  toggle count of the last completed window

## Operation
- Reset: state STABLE, clk_select=1, on_prog=0, busy=0, fault=0, fault_code=0, last_count=0, all counters 0.
- STABLE: clk_select=1. Go to QUALIFY when switch_req=1, revert_req=0, fault=0, and synced lock=1. switch_req is ignored while fault=1.
- QUALIFY: window counter runs 0..WINDOW_CYCLES-1. Toggle counter increments per edge event and saturates at 2^CNT_W-1.
  - On the terminal cycle: last_count is loaded.
  - In range [MIN,MAX]: go to SETTLE.
  - Below MIN: go to STABLE, fault=1, code 2.
  - Above MAX: go to STABLE, fault=1, code 3.
- SETTLE: counts SETTLE_CYCLES, then goes to PROG. clk_select=0 from the first PROG cycle.
- PROG: clk_select=0. revert_req goes to STABLE with no fault.
- Lock loss (synced lock=0) in QUALIFY, SETTLE or PROG: go to STABLE next cycle, fault=1, code 1.
- revert_req in QUALIFY or SETTLE: abort to STABLE, no fault.
- Simultaneous events, in priority order: lock loss > revert_req > window/settle completion > switch_req.
- A new fault in the same cycle as fault_clr wins: fault stays 1 and takes the new code.
- A fault while fault=1 overwrites fault_code with the latest cause.

## Timing
- prog_locked to internal use: 2 cycles. prog_toggle to counted event: 3 cycles.
- Fallback: one registered cycle after synced lock=0, i.e. clk_select=1 within 3 cycles of the prog_locked fall.
- Minimum switch latency from switch_req to clk_select=0: 1 + WINDOW_CYCLES + SETTLE_CYCLES cycles (synchronizer latency on a prog_locked already high excluded).
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- CLK_SWITCH_ACTIVITY_MON_EN defined: in PROG, windows repeat back-to-back and update last_count each time. An out-of-range window falls back to STABLE with code 2 or 3.
- Not defined: in PROG, only lock is monitored. The toggle counter is idle and last_count holds its QUALIFY value.

## Structure
- Package clk_switch_pkg: state enumeration (STABLE, QUALIFY, SETTLE, PROG) and fault code constants.
- Sub-module clk_activity_meter: toggle synchronizer, edge detect, window counter and saturating toggle counter. It exposes window_done and count; the FSM stays in the top level.

## Test plan
- Reset release with inputs idle -> clk_select=1, fault=0, last_count=0.
- Lock high, 500 toggles per window, switch_req held -> last_count=500, busy for 1088 cycles, clk_select=0 at cycle 1089, on_prog=1.
- 300 toggles per window -> STABLE, fault=1, fault_code=2, clk_select never 0. Later switch_req is ignored until fault_clr.
- In PROG, drop prog_locked -> clk_select=1 within 3 cycles, fault_code=1.
- switch_req and revert_req together in STABLE, then revert_req asserted mid-SETTLE -> no transition out of STABLE in the first case, abort to STABLE with fault=0 in the second.
- With CLK_SWITCH_ACTIVITY_MON_EN, raise the rate to 700 per window while in PROG -> fallback, fault_code=3. Without the macro -> stays in PROG.
